garage_door_ctrl_multi: RTL and testbench
=========================================

Name: garage_door_ctrl_multi

Overview:
- Parametrised next-generation garage door controller serving N_DOORS independent bays, one Moore FSM per bay.
- Adds over the single-door controller:
  - edge-triggered Activate
  - stop-mid-travel and resume in the opposite direction
  - obstruction auto-reverse while closing
  - motor run-time watchdog
  - sticky per-bay fault state with explicit clear
- Sits between debounced panel and sensor inputs and the motor driver enables.

Parameters:
- N_DOORS, 2, number of independent bays/channels.
- MAX_RUN_CYCLES, 1000, maximum clk cycles a motor may run before a watchdog fault is raised; must be >= 2.
- CNT_W, $clog2(MAX_RUN_CYCLES+1), run timer width (derived, do not override).

Ports:
- clk        in   1        system clock.
- rst        in   1        reset, asynchronous, active-low.
- activate   in   N_DOORS  per-bay push button, level, synchronous; only rising edges act.
- up_max     in   N_DOORS  per-bay fully-open limit switch.
- dn_max     in   N_DOORS  per-bay fully-closed limit switch.
- obstruct   in   N_DOORS  per-bay beam-break sensor, 1 = blocked.
- fault_clr  in   N_DOORS  per-bay fault clear, level-sampled.
- up_m       out  N_DOORS  per-bay motor-up enable.
- dn_m       out  N_DOORS  per-bay motor-down enable.
- stopped    out  N_DOORS  per-bay: door halted mid-travel.
- fault      out  N_DOORS  per-bay: bay in FAULT.

Behaviour:
- Channels are fully independent: no shared state, no arbitration.
- Each channel holds:
  - state register {IDLE, MV_UP, MV_DN, STOP, FAULT}
  - last_dir flag (1 = was moving up)
  - act_q register
  - CNT_W-bit run timer
- Reset (rst low, async):
  - state = IDLE, last_dir = 0, act_q = 0, timer = 0.
  - All outputs 0.
- Activate edge detection:
  - act_q <= activate every cycle.
  - act_p = activate & ~act_q.
  - Holding activate high produces exactly one act_p.
  - act_p is evaluated in the same cycle. The state and outputs change at the clock edge where activate is first sampled high, so outputs are visible 1 cycle after the stimulus is applied.
- Outputs are pure Moore decodes of state:
  - up_m = (MV_UP)
  - dn_m = (MV_DN)
  - stopped = (STOP)
  - fault = (FAULT)
  - up_m and dn_m are never both 1.
- Global rule: up_max & dn_max both 1 in any non-FAULT state -> FAULT. This has top priority.
- IDLE transitions:
  - act_p & dn_max -> MV_UP.
  - act_p & up_max -> MV_DN.
  - act_p with neither limit (position unknown) -> MV_UP.
  - Otherwise stay in IDLE.
- MV_UP (priority order):
  - up_max -> IDLE.
  - timer == MAX_RUN_CYCLES-1 -> FAULT.
  - act_p -> STOP, last_dir = 1.
  - obstruct is ignored while opening.
- MV_DN (priority order):
  - dn_max -> IDLE.
  - obstruct -> MV_UP (auto-reverse; timer restarts).
  - timer == MAX_RUN_CYCLES-1 -> FAULT.
  - act_p -> STOP, last_dir = 0.
- STOP transitions:
  - act_p & last_dir -> MV_DN.
  - act_p & ~last_dir -> MV_UP.
  - Otherwise stay; remains in STOP indefinitely.
- FAULT transitions:
  - fault_clr = 1 -> IDLE; act_p is ignored in that cycle.
  - Any other inputs are ignored.
  - If both limits are still 1, the next cycle re-enters FAULT.
- Run timer:
  - Cleared to 0 on every entry into MV_UP/MV_DN, including direct MV_DN->MV_UP reversal.
  - Increments by 1 each cycle spent in MV_UP or MV_DN.
  - Held at 0 in other states.
  - Never wraps: the FAULT transition fires at count MAX_RUN_CYCLES-1, giving exactly MAX_RUN_CYCLES motor-on cycles.
- Simultaneous events resolve by the priority lists above:
  - A limit reached in the same cycle as act_p goes to IDLE.
  - obstruct with act_p in MV_DN goes to MV_UP.
- Reset mid-travel: motors drop to 0 asynchronously with rst assertion. After release the bay is in IDLE and needs a new act_p.

Test Plan (N_DOORS=2, MAX_RUN_CYCLES=16):
- Bay0 dn_max=1, activate 0->1 held 5 cycles -> up_m[0]=1 one cycle later, single act_p only. Set up_max=1, dn_max=0 after 6 cycles -> up_m[0]=0 next cycle, state IDLE. Bay1 outputs stay 0 throughout.
- Bay0 up_max=1, act_p -> dn_m[0]=1. Release up_max, then obstruct=1 at cycle 4 -> next cycle dn_m[0]=0, up_m[0]=1, timer restarts at 0.
- Bay1 moving up, act_p at cycle 3 -> stopped[1]=1, both motors 0. Hold 20 cycles, then act_p -> dn_m[1]=1.
- Bay0 moving down with no limit -> dn_m[0] high exactly 16 cycles, then fault[0]=1. activate pulses are ignored. fault_clr=1 for one cycle -> IDLE, fault[0]=0.
- up_max[1]=dn_max[1]=1 while IDLE -> fault[1]=1 next cycle. fault_clr with limits still both 1 -> IDLE for one cycle, then FAULT again.
- Both bays moving, rst pulled low mid-cycle -> up_m=dn_m=0 immediately (async). After release, all outputs 0 until a new activate edge.

Source files
------------

// File: rtl/garage_door_ctrl_multi_if.sv
// Panel/sensor inputs and motor-driver outputs for an N-bay garage door controller.
//   activate  : per-bay push button (level; rising edge acts)
//   up_max    : per-bay fully-open limit switch
//   dn_max    : per-bay fully-closed limit switch
//   obstruct  : per-bay beam-break sensor, 1 = blocked
//   fault_clr : per-bay fault clear
//   up_m/dn_m : per-bay motor up/down enables
//   stopped   : per-bay door halted mid-travel
//   fault     : per-bay in FAULT
interface garage_door_ctrl_multi_if #(
   parameter int unsigned N_DOORS = 2
);
   logic [N_DOORS-1:0] activate;
   logic [N_DOORS-1:0] up_max;
   logic [N_DOORS-1:0] dn_max;
   logic [N_DOORS-1:0] obstruct;
   logic [N_DOORS-1:0] fault_clr;
   logic [N_DOORS-1:0] up_m;
   logic [N_DOORS-1:0] dn_m;
   logic [N_DOORS-1:0] stopped;
   logic [N_DOORS-1:0] fault;

   // Panel/sensor side
   modport master (
      output activate, up_max, dn_max, obstruct, fault_clr,
      input  up_m, dn_m, stopped, fault
   );

   // Controller side
   modport slave (
      input  activate, up_max, dn_max, obstruct, fault_clr,
      output up_m, dn_m, stopped, fault
   );
endinterface

// File: rtl/garage_door_ctrl_multi.sv
// Multi-bay garage door controller: one independent Moore FSM per bay with
// edge-triggered activate, stop/resume, obstruction auto-reverse while closing,
// motor run-time watchdog and sticky fault with explicit clear.
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : garage_door_ctrl_multi_if.slave (inputs activate/up_max/dn_max/
//         obstruct/fault_clr, outputs up_m/dn_m/stopped/fault)
module garage_door_ctrl_multi #(
   parameter int unsigned N_DOORS        = 2,
   parameter int unsigned MAX_RUN_CYCLES = 1000
) (
   input  logic                     clk,
   input  logic                     rst,
   garage_door_ctrl_multi_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(MAX_RUN_CYCLES + 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] MV_UP = 3'd1;
   localparam logic [2:0] MV_DN = 3'd2;
   localparam logic [2:0] STOP  = 3'd3;
   localparam logic [2:0] FAULT = 3'd4;

   // Count value at which the motor has been on for MAX_RUN_CYCLES cycles
   localparam logic [CNT_W-1:0] T_LAST = CNT_W'(MAX_RUN_CYCLES - 1);

   logic [2:0]         state_q  [N_DOORS];
   logic [2:0]         state_nx [N_DOORS];
   logic [CNT_W-1:0]   timer_q  [N_DOORS];
   logic [CNT_W-1:0]   timer_nx [N_DOORS];
   logic [N_DOORS-1:0] last_dir_q, last_dir_nx;
   logic [N_DOORS-1:0] act_q;
   logic [N_DOORS-1:0] act_p_c;
   logic [N_DOORS-1:0] up_m_q, up_m_nx;
   logic [N_DOORS-1:0] dn_m_q, dn_m_nx;
   logic [N_DOORS-1:0] stopped_q, stopped_nx;
   logic [N_DOORS-1:0] fault_q, fault_nx;

   // Rising edge of activate, acted on in the cycle it is first seen
   assign act_p_c = bus.activate & ~act_q;

   // Per-bay next state, run timer and output decode
   always_comb begin
      up_m_nx     = '0;
      dn_m_nx     = '0;
      stopped_nx  = '0;
      fault_nx    = '0;
      last_dir_nx = last_dir_q;
      for (int i = 0; i < int'(N_DOORS); i++) begin
         state_nx[i] = state_q[i];
         timer_nx[i] = '0;

         if (state_q[i] != FAULT && bus.up_max[i] && bus.dn_max[i]) begin
            state_nx[i] = FAULT;
         end else begin
            case (state_q[i])
               IDLE: begin
                  if (act_p_c[i]) begin
                     // Unknown position defaults to opening
                     state_nx[i] = (bus.up_max[i] && !bus.dn_max[i]) ? MV_DN : MV_UP;
                  end
               end
               MV_UP: begin
                  if (bus.up_max[i]) begin
                     state_nx[i] = IDLE;
                  end else if (timer_q[i] == T_LAST) begin
                     state_nx[i] = FAULT;
                  end else if (act_p_c[i]) begin
                     state_nx[i]    = STOP;
                     last_dir_nx[i] = 1'b1;
                  end
               end
               MV_DN: begin
                  if (bus.dn_max[i]) begin
                     state_nx[i] = IDLE;
                  end else if (bus.obstruct[i]) begin
                     state_nx[i] = MV_UP;
                  end else if (timer_q[i] == T_LAST) begin
                     state_nx[i] = FAULT;
                  end else if (act_p_c[i]) begin
                     state_nx[i]    = STOP;
                     last_dir_nx[i] = 1'b0;
                  end
               end
               STOP: begin
                  if (act_p_c[i]) begin
                     state_nx[i] = last_dir_q[i] ? MV_DN : MV_UP;
                  end
               end
               FAULT: begin
                  if (bus.fault_clr[i]) begin
                     state_nx[i] = IDLE;
                  end
               end
               default: state_nx[i] = IDLE;
            endcase
         end

         // Timer restarts on any entry into a moving state, including reversal
         if ((state_nx[i] == MV_UP || state_nx[i] == MV_DN) && state_nx[i] == state_q[i]) begin
            timer_nx[i] = timer_q[i] + CNT_W'(1);
         end

         up_m_nx[i]    = (state_nx[i] == MV_UP);
         dn_m_nx[i]    = (state_nx[i] == MV_DN);
         stopped_nx[i] = (state_nx[i] == STOP);
         fault_nx[i]   = (state_nx[i] == FAULT);
      end
   end

   // State, timer, edge-detect and registered output decode
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(N_DOORS); i++) begin
            state_q[i] <= IDLE;
            timer_q[i] <= '0;
         end
         last_dir_q <= '0;
         act_q      <= '0;
         up_m_q     <= '0;
         dn_m_q     <= '0;
         stopped_q  <= '0;
         fault_q    <= '0;
      end else begin
         for (int i = 0; i < int'(N_DOORS); i++) begin
            state_q[i] <= state_nx[i];
            timer_q[i] <= timer_nx[i];
         end
         last_dir_q <= last_dir_nx;
         act_q      <= bus.activate;
         up_m_q     <= up_m_nx;
         dn_m_q     <= dn_m_nx;
         stopped_q  <= stopped_nx;
         fault_q    <= fault_nx;
      end
   end

   assign bus.up_m    = up_m_q;
   assign bus.dn_m    = dn_m_q;
   assign bus.stopped = stopped_q;
   assign bus.fault   = fault_q;

endmodule

// File: tb/tb_garage_door_ctrl_multi.sv
// Directed, table-driven bench for garage_door_ctrl_multi (2 bays, 16-cycle watchdog).
module tb_garage_door_ctrl_multi;

   localparam int unsigned N   = 2;
   localparam int unsigned MRC = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;

   garage_door_ctrl_multi_if #(.N_DOORS(N)) bus ();

   garage_door_ctrl_multi #(.N_DOORS(N), .MAX_RUN_CYCLES(MRC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [1:0] act, upx, dnx, obs, clr;
      logic [1:0] eup, edn, est, eflt;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic add(input string tag,
                      input logic [1:0] act, input logic [1:0] upx, input logic [1:0] dnx,
                      input logic [1:0] obs, input logic [1:0] clr,
                      input logic [1:0] eup, input logic [1:0] edn,
                      input logic [1:0] est, input logic [1:0] eflt);
      vec_t v;
      v.tag = tag; v.act = act; v.upx = upx; v.dnx = dnx; v.obs = obs; v.clr = clr;
      v.eup = eup; v.edn = edn; v.est = est; v.eflt = eflt;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [1:0] act, input logic [1:0] upx, input logic [1:0] dnx,
                        input logic [1:0] obs, input logic [1:0] clr);
      bus.activate  = act;
      bus.up_max    = upx;
      bus.dn_max    = dnx;
      bus.obstruct  = obs;
      bus.fault_clr = clr;
   endtask

   task automatic check(input string tag, input logic [1:0] eup, input logic [1:0] edn,
                        input logic [1:0] est, input logic [1:0] eflt);
      checks++;
      if (bus.up_m !== eup || bus.dn_m !== edn || bus.stopped !== est || bus.fault !== eflt) begin
         failures++;
         $display("FAIL %s @%0t: got up_m=%b dn_m=%b stopped=%b fault=%b, expected up_m=%b dn_m=%b stopped=%b fault=%b",
                  tag, $time, bus.up_m, bus.dn_m, bus.stopped, bus.fault, eup, edn, est, eflt);
      end
   endtask

   initial begin
      // A: bay0 opens from closed, single edge while held, stops at open limit
      add("a_start",   2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      for (int i = 0; i < 4; i++)
         add("a_hold",  2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add("a_travel",  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add("a_open",    2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      // B: bay0 closes, obstruction reverses, timer restarts (16 up cycles)
      add("b_close",   2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
      add("b_dn",      2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
      add("b_obs_rev", 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      for (int i = 0; i < 15; i++)
         add("b_up_run", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add("b_wdog",    2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      add("b_flt_act", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      add("b_flt",     2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      add("b_clr_act", 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
      add("b_held",    2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("b_rel",     2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      // C: bay1 stop mid-opening, long hold, resume closing
      add("c_start",   2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
      add("c_up",      2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
      add("c_up",      2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
      add("c_stop",    2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
      for (int i = 0; i < 20; i++)
         add("c_stay",  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
      add("c_resume",  2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
      add("c_closed",  2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      // D: bay0 closing watchdog, exactly 16 motor-on cycles
      add("d_start",   2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
      for (int i = 0; i < 15; i++)
         add("d_dn_run", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
      add("d_wdog",    2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      add("d_flt_act", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      add("d_flt",     2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      add("d_clr",     2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
      // E: bay1 both limits in IDLE, clear while still both -> re-fault
      add("e_both",    2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
      add("e_clr",     2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
      add("e_refault", 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
      add("e_sticky",  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
      add("e_clr2",    2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
      // Simultaneous events on bay0: limit beats act_p, obstruct beats act_p
      add("s_up",      2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add("s_up2",     2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add("s_lim_act", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("s_idle",    2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("s_dn",      2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
      add("s_dn2",     2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
      add("s_obs_act", 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add("s_open",    2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      // Both limits while moving -> fault
      add("g_up",      2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add("g_both",    2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      add("g_clr",     2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
      add("g_idle",    2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      // Stop while closing resumes opening
      add("r_dn",      2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
      add("r_dn2",     2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
      add("r_stop",    2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
      add("r_stay",    2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
      add("r_resume",  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add("r_open",    2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("r_end",     2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

      drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("reset", 2'b00, 2'b00, 2'b00, 2'b00);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[k]) begin
         @(negedge clk);
         drive(vecs[k].act, vecs[k].upx, vecs[k].dnx, vecs[k].obs, vecs[k].clr);
         @(posedge clk);
         #1 check(vecs[k].tag, vecs[k].eup, vecs[k].edn, vecs[k].est, vecs[k].eflt);
      end

      // Async reset mid-travel on both bays
      @(negedge clk);
      drive(2'b11, 2'b00, 2'b11, 2'b00, 2'b00);
      @(posedge clk);
      #1 check("f_both_up", 2'b11, 2'b00, 2'b00, 2'b00);
      #2 rst = 1'b0;
      #1 check("f_async_rst", 2'b00, 2'b00, 2'b00, 2'b00);
      @(negedge clk);
      bus.activate = 2'b00;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1 check("f_post_rst", 2'b00, 2'b00, 2'b00, 2'b00);
      end
      @(negedge clk);
      bus.activate = 2'b11;
      @(posedge clk);
      #1 check("f_new_edge", 2'b11, 2'b00, 2'b00, 2'b00);
      @(negedge clk);
      drive(2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
      @(posedge clk);
      #1 check("f_open", 2'b00, 2'b00, 2'b00, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
